// File: rtl/bounce_rect_sequencer.sv
// Per-frame draw-request sequencer for NUM_RECTS bouncing, hue-cycling rectangles.
// Issues one valid/ready request per object per accepted frame_start, then moves and recolours it.
module bounce_rect_sequencer #(
  parameter int NUM_RECTS = 4,
  parameter int IMG_W     = 1920,
  parameter int IMG_H     = 1080,
  parameter int RECT_W    = 400,
  parameter int RECT_H    = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_start,
  input  logic [3:0]  speed,
  output logic [15:0] req_x,
  output logic [15:0] req_y,
  output logic [15:0] req_w,
  output logic [15:0] req_h,
  output logic [31:0] req_color,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] overrun_cnt
);

  localparam int          IDX_W    = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;
  localparam logic [15:0] MAX_X    = 16'(IMG_W - RECT_W);
  localparam logic [15:0] MAX_Y    = 16'(IMG_H - RECT_H);
  localparam int          STEP_X   = (IMG_W - RECT_W) / NUM_RECTS;
  localparam int          STEP_Y   = (IMG_H - RECT_H) / NUM_RECTS;
  localparam int          HUE_STEP = 1536 / NUM_RECTS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [IDX_W-1:0]   idx_r;
  logic [3:0]         speed_r;
  logic [15:0]        x_r      [NUM_RECTS];
  logic [15:0]        y_r      [NUM_RECTS];
  logic               dx_neg_r [NUM_RECTS];
  logic               dy_neg_r [NUM_RECTS];
  logic [10:0]        hue_r    [NUM_RECTS];
  logic               accept_s;
  logic               overrun_s;
  logic               handshake_s;
  logic               last_s;
  logic               valid_next_s;
  logic               busy_next_s;

  // One axis step with exact-edge clamping; returns {new_dir_negative, new_pos}.
  function automatic logic [16:0] move_axis(input logic [15:0] pos, input logic neg,
                                            input logic [3:0] spd, input logic [15:0] max_pos);
    logic [16:0] sum;
    logic [16:0] res;
    sum = {1'b0, pos} + {13'd0, spd};
    if (spd == 4'd0) begin
      res = {neg, pos};
    end else if (!neg) begin
      if (sum >= {1'b0, max_pos}) res = {1'b1, max_pos};
      else                        res = {1'b0, sum[15:0]};
    end else begin
      if ({1'b0, pos} <= {13'd0, spd}) res = {1'b0, 16'd0};
      else                             res = {1'b1, pos - {12'd0, spd}};
    end
    return res;
  endfunction

  // Six-sextant hue wheel to {8'h00, B, G, R}; ~s is 255-s.
  function automatic logic [31:0] hue_to_color(input logic [10:0] h);
    logic [7:0]  s;
    logic [31:0] c;
    s = h[7:0];
    case (h[10:8])
      3'd0:    c = {8'h00, 8'h00, s,     8'hFF};
      3'd1:    c = {8'h00, 8'h00, 8'hFF, ~s   };
      3'd2:    c = {8'h00, s,     8'hFF, 8'h00};
      3'd3:    c = {8'h00, 8'hFF, ~s,    8'h00};
      3'd4:    c = {8'h00, 8'hFF, 8'h00, s    };
      3'd5:    c = {8'h00, ~s,    8'h00, 8'hFF};
      default: c = 32'h0000_0000;
    endcase
    return c;
  endfunction

  assign accept_s    = (state_r == ST_IDLE) && frame_start && enable;
  assign overrun_s   = (state_r != ST_IDLE) && frame_start && enable;
  assign handshake_s = (state_r == ST_REQ) && req_ready;
  assign last_s      = (idx_r == IDX_W'(NUM_RECTS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_LOAD;
        else          state_next_s = ST_IDLE;
      end
      ST_LOAD: state_next_s = ST_REQ;
      ST_REQ: begin
        if (!req_ready)  state_next_s = ST_REQ;
        else if (last_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_LOAD;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode, registered below so req_valid/busy come straight from flops.
  always_comb begin
    valid_next_s = 1'b0;
    busy_next_s  = 1'b0;
    case (state_next_s)
      ST_IDLE: begin valid_next_s = 1'b0; busy_next_s = 1'b0; end
      ST_LOAD: begin valid_next_s = 1'b0; busy_next_s = 1'b1; end
      ST_REQ:  begin valid_next_s = 1'b1; busy_next_s = 1'b1; end
      default: begin valid_next_s = 1'b0; busy_next_s = 1'b0; end
    endcase
  end

  // Control counters and the request register set.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= '0;
      speed_r     <= 4'd0;
      frame_cnt   <= 16'd0;
      overrun_cnt <= 16'd0;
      req_x       <= 16'd0;
      req_y       <= 16'd0;
      req_color   <= 32'd0;
      req_w       <= 16'(RECT_W);
      req_h       <= 16'(RECT_H);
      req_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      req_w     <= 16'(RECT_W);
      req_h     <= 16'(RECT_H);
      req_valid <= valid_next_s;
      busy      <= busy_next_s;
      if (accept_s) begin
        speed_r   <= speed;
        frame_cnt <= frame_cnt + 16'd1;
        idx_r     <= '0;
      end else if (handshake_s && !last_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
      if (overrun_s && (overrun_cnt != 16'hFFFF)) overrun_cnt <= overrun_cnt + 16'd1;
      else                                        overrun_cnt <= overrun_cnt;
      // Snapshot taken before the move so the request shows this frame's start position.
      if (state_r == ST_LOAD) begin
        req_x     <= x_r[idx_r];
        req_y     <= y_r[idx_r];
        req_color <= hue_to_color(hue_r[idx_r]);
      end else begin
        req_x     <= req_x;
        req_y     <= req_y;
        req_color <= req_color;
      end
    end
  end

  // Object state: staggered initial placement, move and hue step on each handshake.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RECTS; i++) begin
      if (rst) begin
        x_r[i]      <= 16'(i * STEP_X);
        y_r[i]      <= 16'(i * STEP_Y);
        dx_neg_r[i] <= 1'b0;
        dy_neg_r[i] <= 1'b0;
        hue_r[i]    <= 11'(i * HUE_STEP);
      end else if (handshake_s && (idx_r == IDX_W'(i))) begin
        {dx_neg_r[i], x_r[i]} <= move_axis(x_r[i], dx_neg_r[i], speed_r, MAX_X);
        {dy_neg_r[i], y_r[i]} <= move_axis(y_r[i], dy_neg_r[i], speed_r, MAX_Y);
        hue_r[i] <= (hue_r[i] == 11'd1535) ? 11'd0 : hue_r[i] + 11'd1;
      end else begin
        x_r[i]      <= x_r[i];
        y_r[i]      <= y_r[i];
        dx_neg_r[i] <= dx_neg_r[i];
        dy_neg_r[i] <= dy_neg_r[i];
        hue_r[i]    <= hue_r[i];
      end
    end
  end

endmodule
